instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Reader side of the program counter. Owns the fetch PC and issues read requests
//   to instruction memory over a req/ack handshake.
//   Buffers returned instructions in a small queue and presents them, tagged with
//   their PC, to decode over a valid/ready handshake. Decode stalls by dropping
//   dec_ready. Taken branches and jumps flush the queue through redirect.
// PARAMETERS
//   ADDR_W   16  fetch PC / memory address width
//   DATA_W   16  instruction width
//   DEPTH     2  instruction queue entries (power of 2, >=2)
//   PC_INC    2  PC increment per instruction (byte addressing)
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-low
//   redirect     in   1       flush queue, restart fetch at redirect_pc
//   redirect_pc  in   ADDR_W  new fetch PC
//   imem_req     out  1       read request, held until imem_ack
//   imem_addr    out  ADDR_W  read address, stable while imem_req=1
//   imem_ack     in   1       read data valid; only meaningful while imem_req=1
//   imem_rdata   in   DATA_W  instruction word, sampled when imem_ack=1
//   dec_valid    out  1       queue head valid
//   dec_instr    out  DATA_W  queue head instruction
//   dec_pc       out  ADDR_W  PC of queue head instruction
//   dec_ready    in   1       decode accepts head (pop = dec_valid & dec_ready)
//   fetch_pc     out  ADDR_W  PC of next instruction to request
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, fetch_pc=0, queue count=0, imem_req=0,
//     dec_valid=0, dec_instr=0, dec_pc=0. Any outstanding request is abandoned.
//   FSM states: IDLE, REQ, FLUSH. At most one request is outstanding.
//     IDLE : no redirect and count<DEPTH -> REQ (imem_req=1 next cycle,
//            imem_addr=fetch_pc). Otherwise stay.
//     REQ  : imem_req=1, imem_addr=fetch_pc held.
//            ack & !redirect -> push {fetch_pc, rdata}; fetch_pc += PC_INC.
//              If count_after_push_and_pop < DEPTH, stay REQ with the new address
//              (back-to-back, 1 instr/cycle with a 1-cycle memory); else go IDLE.
//            redirect & ack -> discard data, go IDLE.
//            redirect & !ack -> go FLUSH.
//     FLUSH: imem_req stays 1 with the stale address until ack. Ack data is discarded.
//            On ack, go IDLE. A redirect in FLUSH only updates fetch_pc.
//   imem_addr is registered, and so is the stale address in FLUSH. fetch_pc is
//     updated separately at redirect.
//   Redirect has priority over push and pop in the same cycle:
//     - count <= 0
//     - fetch_pc <= redirect_pc
//     - dec_valid is 0 from the next cycle onward
//   Queue: circular buffer, registered pointers. dec_* are driven combinationally
//     from the head, so the latency from ack to dec_valid is 1 cycle.
//     Push and pop in the same cycle is legal. Count is unchanged.
//     Overflow is impossible: a request is only issued when count<DEPTH.
//     Pop on empty is ignored.
//   dec_instr and dec_pc hold their value while dec_valid=1 & dec_ready=0.
//   fetch_pc arithmetic is modulo 2^ADDR_W (0xFFFE + 2 -> 0x0000). There is no
//     alignment check.
// TESTING
//   1 Memory acks 1 cycle after req with rdata=addr^16'hA5A5, dec_ready=1 ->
//     dec_pc 0x0000,0x0002,0x0004.., instr 0xA5A5,0xA5A7,0xA5A1.., with no gaps.
//   2 dec_ready=0 from reset -> 2 entries fill (pc 0,2), imem_req=0 afterwards.
//     Raise dec_ready -> pops in order, next req addr 0x0004.
//   3 Redirect to 0x0100 while REQ waits (ack 3 cycles later) -> FLUSH.
//     dec_valid=0 next cycle, stale data not pushed, next req addr 0x0100.
//   4 Redirect to 0x0040 in the same cycle as ack and a pop -> data discarded,
//     count=0, next imem_addr=0x0040.
//   5 Redirect to 0xFFFE, dec_ready=1 -> dec_pc 0xFFFE then 0x0000.
//   6 rst low mid-REQ with a full queue -> outputs at reset values immediately
//     (before clk). After release, the first req addr is 0x0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory over req/ack
// and queues returned words, tagged with their PC, for decode over valid/ready.
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int PC_INC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dec_valid,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC_C = ADDR_W'(PC_INC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   fetch_pc_r;
    logic [ADDR_W-1:0]   fetch_pc_s;
    logic [ADDR_W-1:0]   pc_inc_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_s;
    logic                req_r;
    logic                req_s;
    logic                push_s;
    logic                pop_s;
    logic [CNT_W-1:0]    count_after_s;
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;
    logic [ADDR_W-1:0]   q_pc_r    [DEPTH];
    logic [DATA_W-1:0]   q_instr_r [DEPTH];

    assign pc_inc_s  = fetch_pc_r + PC_INC_C;
    assign pop_s     = (count_r != CNT_W'(0)) && dec_ready && !redirect;
    // In REQ the count never exceeds DEPTH-1, so +1 cannot wrap the counter.
    assign count_after_s = count_r + CNT_W'(1) - (pop_s ? CNT_W'(1) : CNT_W'(0));

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign fetch_pc  = fetch_pc_r;
    assign dec_valid = (count_r != CNT_W'(0));
    assign dec_instr = q_instr_r[head_r];
    assign dec_pc    = q_pc_r[head_r];

    // Fetch FSM next state, request register next values and push decision.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        req_s      = req_r;
        push_s     = 1'b0;
        fetch_pc_s = fetch_pc_r;
        case (state_r)
            IDLE: begin
                if (!redirect && (count_r < DEPTH_C)) begin
                    state_s = REQ;
                    req_s   = 1'b1;
                    addr_s  = fetch_pc_r;
                end else begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (imem_ack) begin
                        state_s = IDLE;
                        req_s   = 1'b0;
                    end else begin
                        // The memory still owes an answer; keep asking for the stale address.
                        state_s = FLUSH;
                    end
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_s = pc_inc_s;
                    if (count_after_s < DEPTH_C) begin
                        addr_s = pc_inc_s;
                    end else begin
                        state_s = IDLE;
                        req_s   = 1'b0;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    state_s = IDLE;
                    req_s   = 1'b0;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
        if (redirect) begin
            fetch_pc_s = redirect_pc;
        end else begin
            fetch_pc_s = fetch_pc_s;
        end
    end

    // FSM state, fetch PC and memory request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= {ADDR_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            req_r      <= req_s;
        end
    end

    // Instruction queue: circular buffer; redirect empties it ahead of push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]    <= {ADDR_W{1'b0}};
                q_instr_r[i] <= {DATA_W{1'b0}};
            end
        end else if (redirect) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                q_pc_r[tail_r]    <= fetch_pc_r;
                q_instr_r[tail_r] <= imem_rdata;
                tail_r            <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a responding memory model whose
// ack latency is adjustable; data returned is always addr ^ 16'hA5A5.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        dec_ready;
    logic [15:0] fetch_pc;

    int checks;
    int errors;
    int ack_delay;
    int wait_cnt;

    instr_fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(2), .PC_INC(2)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_ready(dec_ready), .fetch_pc(fetch_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: answers each request after ack_delay idle cycles.
    always @(negedge clk) begin
        if (!rst || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ 16'hA5A5;
            wait_cnt   = 0;
        end else begin
            imem_ack = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready, input int delay);
        rst       = 1'b0;
        redirect  = 1'b0;
        redirect_pc = 16'h0000;
        dec_ready = ready;
        ack_delay = delay;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b0 || dec_instr !== 16'h0000 ||
            dec_pc !== 16'h0000 || fetch_pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values req=%b valid=%b instr=%h pc=%h fpc=%h expected 0,0,0000,0000,0000",
                     imem_req, dec_valid, dec_instr, dec_pc, fetch_pc);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        do_reset(1'b1, 0);
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL stream_first_req req=%b addr=%h expected 1 0000", imem_req, imem_addr);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_pc = 16'(2 * i);
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== (exp_pc ^ 16'hA5A5)) begin
                errors++;
                $display("FAIL stream_%0d valid=%b pc=%h instr=%h expected 1 %h %h",
                         i, dec_valid, dec_pc, dec_instr, exp_pc, exp_pc ^ 16'hA5A5);
            end
            if (i == 2) begin
                checks++;
                if (dec_instr !== 16'hA5A1) begin
                    errors++;
                    $display("FAIL stream_third_instr got %h expected a5a1", dec_instr);
                end
            end
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset(1'b0, 0);
        repeat (5) tick();
        checks++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 16'h0000 || dec_instr !== 16'hA5A5) begin
            errors++;
            $display("FAIL stall_full req=%b valid=%b pc=%h instr=%h expected 0 1 0000 a5a5",
                     imem_req, dec_valid, dec_pc, dec_instr);
        end
        dec_ready = 1'b1;
        tick();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0002 || dec_instr !== 16'hA5A7) begin
            errors++;
            $display("FAIL stall_second valid=%b pc=%h instr=%h expected 1 0002 a5a7",
                     dec_valid, dec_pc, dec_instr);
        end
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL stall_next_req req=%b addr=%h expected 1 0004", imem_req, imem_addr);
        end
    endtask

    task automatic test_flush();
        int n;
        do_reset(1'b1, 3);
        repeat (2) tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000 || fetch_pc !== 16'h0100) begin
            errors++;
            $display("FAIL flush_enter valid=%b req=%b addr=%h fpc=%h expected 0 1 0000 0100",
                     dec_valid, imem_req, imem_addr, fetch_pc);
        end
        repeat (2) tick();
        checks++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard req=%b valid=%b expected 0 0", imem_req, dec_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL flush_new_req req=%b addr=%h expected 1 0100", imem_req, imem_addr);
        end
        n = 0;
        while (dec_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0100 || dec_instr !== 16'hA4A5) begin
            errors++;
            $display("FAIL flush_first_instr valid=%b pc=%h instr=%h expected 1 0100 a4a5",
                     dec_valid, dec_pc, dec_instr);
        end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset(1'b1, 0);
        repeat (2) tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || imem_req !== 1'b0 || fetch_pc !== 16'h0040) begin
            errors++;
            $display("FAIL redir_ack valid=%b req=%b fpc=%h expected 0 0 0040",
                     dec_valid, imem_req, fetch_pc);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL redir_ack_req req=%b addr=%h expected 1 0040", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0040 || dec_instr !== 16'hA5E5) begin
            errors++;
            $display("FAIL redir_ack_instr valid=%b pc=%h instr=%h expected 1 0040 a5e5",
                     dec_valid, dec_pc, dec_instr);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 0);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_req req=%b addr=%h expected 1 fffe", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'hFFFE || dec_instr !== 16'h5A5B || fetch_pc !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_top valid=%b pc=%h instr=%h fpc=%h expected 1 fffe 5a5b 0000",
                     dec_valid, dec_pc, dec_instr, fetch_pc);
        end
        tick();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 16'h0000 || dec_instr !== 16'hA5A5) begin
            errors++;
            $display("FAIL wrap_zero valid=%b pc=%h instr=%h expected 1 0000 a5a5",
                     dec_valid, dec_pc, dec_instr);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0, 0);
        repeat (2) tick();
        checks++;
        if (dec_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL areset_pre valid=%b req=%b addr=%h expected 1 1 0002",
                     dec_valid, imem_req, imem_addr);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b0 || dec_instr !== 16'h0000 ||
            dec_pc !== 16'h0000 || fetch_pc !== 16'h0000) begin
            errors++;
            $display("FAIL areset_now req=%b valid=%b instr=%h pc=%h fpc=%h expected 0 0 0000 0000 0000",
                     imem_req, dec_valid, dec_instr, dec_pc, fetch_pc);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL areset_first_req req=%b addr=%h expected 1 0000", imem_req, imem_addr);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        ack_delay   = 0;
        wait_cnt    = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        dec_ready   = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_redirect_ack_pop();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
